psum_group_reduce_seq: RTL and testbench

- Sequencer that takes one compute round of NUM_MACRO macro partial sums, each tagged with its output-filter index.
- Groups macros that share a filter index; the leader is the lowest-index macro of each group.
- Emits one reduced sum per unique filter, in ascending leader order, over a valid/ready stream.
- Sits between the macro array and the output-channel accumulator/writeback. It owns sharing of the single reduction adder among filter groups.

---
 rtl/psum_group_reduce_seq.sv | 206 ++++++++++++++++++++
 tb/tb_psum_group_reduce_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_group_reduce_seq.sv
// Groups one round of macro partial sums by filter index and streams one reduced
// sum per unique filter, in ascending leader order, through a single adder tree.
module psum_group_reduce_seq #(
    parameter int unsigned NUM_MACRO = 16,
    parameter int unsigned OUT_CH    = 512,
    parameter int unsigned PSUM_W    = 16,
    localparam int unsigned BIT_OUT_CH = $clog2(OUT_CH),
    localparam int unsigned OUT_W      = PSUM_W + $clog2(NUM_MACRO),
    localparam int unsigned CNT_W      = $clog2(NUM_MACRO) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER,
    input  logic [NUM_MACRO*PSUM_W-1:0]     PSUM,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BIT_OUT_CH-1:0]           out_filter,
    output logic [OUT_W-1:0]                out_sum,
    output logic [CNT_W-1:0]                out_count,
    output logic                            out_last,
    output logic                            done
);

    localparam int unsigned IDX_W = $clog2(NUM_MACRO);

    typedef enum logic [1:0] {
        IDLE,
        GROUP,
        EMIT
    } state_t;

    state_t state_q, state_d;

    logic [BIT_OUT_CH-1:0] filt_q        [NUM_MACRO];
    logic [PSUM_W-1:0]     psum_q        [NUM_MACRO];
    logic [NUM_MACRO-1:0]  member_mask_q [NUM_MACRO];
    logic [NUM_MACRO-1:0]  leader_mask_q;
    logic [IDX_W-1:0]      cur_q;

    logic [NUM_MACRO-1:0]  leader_c;
    logic [NUM_MACRO-1:0]  member_c      [NUM_MACRO];
    logic [NUM_MACRO-1:0]  sel_leaders_c;
    logic [NUM_MACRO-1:0]  sel_members_c;
    logic [IDX_W-1:0]      nxt_cur_c;
    logic [OUT_W-1:0]      nxt_sum_c;
    logic [CNT_W-1:0]      nxt_count_c;
    logic [CNT_W-1:0]      lead_cnt_c;
    logic                  nxt_last_c;
    logic                  accept_c;
    logic                  hs_c;

    assign accept_c = in_valid && in_ready;
    assign hs_c     = out_valid && out_ready;

    // A macro leads its group when no lower-index macro shares its filter.
    always_comb begin
        leader_c = '0;
        for (int i = 0; i < int'(NUM_MACRO); i++) begin
            leader_c[i] = 1'b1;
            for (int j = 0; j < int'(NUM_MACRO); j++) begin
                if (j < i && filt_q[j] == filt_q[i]) begin
                    leader_c[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_MACRO); i++) begin
            member_c[i] = '0;
            for (int j = 0; j < int'(NUM_MACRO); j++) begin
                member_c[i][j] = leader_c[i] && (filt_q[j] == filt_q[i]);
            end
        end
    end

    // Leaders still pending after this cycle: fresh set in GROUP, minus the
    // group being consumed in EMIT.
    always_comb begin
        sel_leaders_c = '0;
        if (state_q == GROUP) begin
            sel_leaders_c = leader_c;
        end else if (state_q == EMIT) begin
            sel_leaders_c = leader_mask_q & ~(NUM_MACRO'(1) << cur_q);
        end
    end

    always_comb begin
        nxt_cur_c  = '0;
        lead_cnt_c = '0;
        for (int i = int'(NUM_MACRO) - 1; i >= 0; i--) begin
            if (sel_leaders_c[i]) begin
                nxt_cur_c  = IDX_W'(i);
                lead_cnt_c = lead_cnt_c + CNT_W'(1);
            end
        end
        nxt_last_c = (lead_cnt_c == CNT_W'(1));
    end

    always_comb begin
        sel_members_c = '0;
        if (state_q == GROUP) begin
            sel_members_c = member_c[nxt_cur_c];
        end else if (state_q == EMIT) begin
            sel_members_c = member_mask_q[nxt_cur_c];
        end
    end

    // Shared reduction adder tree and member count.
    always_comb begin
        nxt_sum_c   = '0;
        nxt_count_c = '0;
        for (int j = 0; j < int'(NUM_MACRO); j++) begin
            if (sel_members_c[j]) begin
                nxt_sum_c   = nxt_sum_c + {{(OUT_W-PSUM_W){psum_q[j][PSUM_W-1]}}, psum_q[j]};
                nxt_count_c = nxt_count_c + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = GROUP;
            GROUP:   state_d = EMIT;
            EMIT:    if (hs_c && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round capture, group masks and the registered result stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_MACRO); i++) begin
                filt_q[i]        <= '0;
                psum_q[i]        <= '0;
                member_mask_q[i] <= '0;
            end
            leader_mask_q <= '0;
            cur_q         <= '0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_filter    <= '0;
            out_sum       <= '0;
            out_count     <= '0;
            out_last      <= 1'b0;
            done          <= 1'b0;
        end else begin
            in_ready <= (state_d == IDLE);
            done     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        for (int i = 0; i < int'(NUM_MACRO); i++) begin
                            filt_q[i] <= WHICH_FILTER[i*BIT_OUT_CH +: BIT_OUT_CH];
                            psum_q[i] <= PSUM[i*PSUM_W +: PSUM_W];
                        end
                    end
                end
                GROUP: begin
                    for (int i = 0; i < int'(NUM_MACRO); i++) begin
                        member_mask_q[i] <= member_c[i];
                    end
                    leader_mask_q <= leader_c;
                    cur_q         <= nxt_cur_c;
                    out_valid     <= 1'b1;
                    out_filter    <= filt_q[nxt_cur_c];
                    out_sum       <= nxt_sum_c;
                    out_count     <= nxt_count_c;
                    out_last      <= nxt_last_c;
                end
                EMIT: begin
                    if (hs_c) begin
                        leader_mask_q <= sel_leaders_c;
                        if (out_last) begin
                            out_valid  <= 1'b0;
                            out_filter <= '0;
                            out_sum    <= '0;
                            out_count  <= '0;
                            out_last   <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            cur_q      <= nxt_cur_c;
                            out_filter <= filt_q[nxt_cur_c];
                            out_sum    <= nxt_sum_c;
                            out_count  <= nxt_count_c;
                            out_last   <= nxt_last_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_group_reduce_seq.sv
// Directed bench for psum_group_reduce_seq: a queue-based group model checked every
// cycle, plus literal expectations for the planned rounds.
module tb_psum_group_reduce_seq;

    localparam int NM = 16;
    localparam int BW = 9;
    localparam int PW = 16;
    localparam int OW = 20;
    localparam int CW = 5;

    typedef struct {
        int f;
        int s;
        int c;
        bit last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NM*BW-1:0]  which_filter;
    logic [NM*PW-1:0]  psum_bus;
    logic              out_valid;
    logic              out_ready;
    logic [BW-1:0]     out_filter;
    logic [OW-1:0]     out_sum;
    logic [CW-1:0]     out_count;
    logic              out_last;
    logic              done;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    int   grp_n  = 0;
    bit   first_pending = 1'b0;
    bit   chk_lat = 1'b1;
    bit   bp_mode = 1'b0;
    int   filt_v [NM];
    int   psum_v [NM];
    exp_t exp_q   [$];
    exp_t res_log [$];
    int   acc_log [$];
    int   done_log[$];

    psum_group_reduce_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .WHICH_FILTER (which_filter),
        .PSUM         (psum_bus),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_filter   (out_filter),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_last     (out_last),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (bp_mode) out_ready = ~out_ready;
        else         out_ready = 1'b1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: one entry per distinct filter in first-appearance order.
    task automatic model_push();
        int f [NM];
        int s [NM];
        bit seen [int];
        exp_t e;
        int g;
        g = 0;
        for (int i = 0; i < NM; i++) begin
            f[i] = int'(which_filter[i*BW +: BW]);
            s[i] = int'($signed(psum_bus[i*PW +: PW]));
        end
        for (int i = 0; i < NM; i++) begin
            if (!seen.exists(f[i])) begin
                seen[f[i]] = 1'b1;
                e.f = f[i];
                e.s = 0;
                e.c = 0;
                e.last = 1'b0;
                for (int j = 0; j < NM; j++) begin
                    if (f[j] == f[i]) begin
                        e.s += s[j];
                        e.c++;
                    end
                end
                exp_q.push_back(e);
                g++;
            end
        end
        exp_q[exp_q.size()-1].last = 1'b1;
        grp_n = g;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", longint'(out_valid), 0);
            chk("rst_outputs", longint'(out_sum) + longint'(out_filter) + longint'(out_count)
                + longint'(out_last) + longint'(done), 0);
            chk("rst_in_ready", longint'(in_ready), 0);
            exp_q.delete();
            first_pending = 1'b0;
        end else begin
            if (done) begin
                chk("done_queue_empty", longint'(exp_q.size()), 0);
                chk("done_in_ready", longint'(in_ready), 1);
                if (chk_lat) chk("done_latency", longint'(cyc), longint'(acc_cyc + 2 + grp_n));
                done_log.push_back(cyc);
            end
            if (out_valid) begin
                if (first_pending) begin
                    chk("first_valid_latency", longint'(cyc), longint'(acc_cyc + 2));
                    first_pending = 1'b0;
                end
                chk("busy_in_ready", longint'(in_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("out_filter", longint'(out_filter), longint'(exp_q[0].f));
                    chk("out_sum", longint'($signed(out_sum)), longint'(exp_q[0].s));
                    chk("out_count", longint'(out_count), longint'(exp_q[0].c));
                    chk("out_last", longint'(out_last), longint'(exp_q[0].last));
                    if (out_ready) begin
                        exp_t r;
                        r.f = int'(out_filter);
                        r.s = int'($signed(out_sum));
                        r.c = int'(out_count);
                        r.last = out_last;
                        res_log.push_back(r);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_outputs_zero", longint'(out_sum) + longint'(out_filter)
                    + longint'(out_count) + longint'(out_last), 0);
            end
            if (in_valid && in_ready) begin
                model_push();
                acc_cyc = cyc;
                acc_log.push_back(cyc);
                first_pending = 1'b1;
            end
        end
    end

    task automatic drive_bus();
        for (int i = 0; i < NM; i++) begin
            which_filter[i*BW +: BW] = BW'(filt_v[i]);
            psum_bus[i*PW +: PW]     = PW'(psum_v[i]);
        end
    endtask

    task automatic set_distinct();
        for (int i = 0; i < NM; i++) begin filt_v[i] = i; psum_v[i] = i + 1; end
    endtask

    task automatic set_same();
        for (int i = 0; i < NM; i++) begin filt_v[i] = 7; psum_v[i] = -100; end
    endtask

    task automatic set_mixed();
        int mf [6] = '{3, 5, 3, 9, 5, 3};
        for (int i = 0; i < NM; i++) begin
            filt_v[i] = (i < 6) ? mf[i] : 9;
            psum_v[i] = 2;
        end
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++k > 200) begin chk("accept_timeout", 1, 0); break; end
        end
    endtask

    task automatic send_round();
        @(posedge clk); #1;
        drive_bus();
        in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (++k > 300) begin chk("done_timeout", 1, 0); break; end
        end
        #1;
    endtask

    task automatic chk_res(input string nm, input int idx, input int f, input int s,
                           input int c, input bit last);
        if (idx >= res_log.size()) begin
            chk({nm, "_missing"}, longint'(res_log.size()), longint'(idx + 1));
        end else begin
            chk({nm, "_filter"}, longint'(res_log[idx].f), longint'(f));
            chk({nm, "_sum"}, longint'(res_log[idx].s), longint'(s));
            chk({nm, "_count"}, longint'(res_log[idx].c), longint'(c));
            chk({nm, "_last"}, longint'(res_log[idx].last), longint'(last));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        which_filter = '0;
        psum_bus = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // All distinct filters
        res_log.delete();
        set_distinct();
        send_round();
        wait_done();
        chk("distinct_n", longint'(res_log.size()), 16);
        chk_res("distinct_0", 0, 0, 1, 1, 1'b0);
        chk_res("distinct_15", 15, 15, 16, 1, 1'b1);
        chk("distinct_done_lat", longint'(done_log[$] - acc_log[$]), 18);

        // All same filter
        res_log.delete();
        set_same();
        send_round();
        wait_done();
        chk("same_n", longint'(res_log.size()), 1);
        chk_res("same_0", 0, 7, -1600, 16, 1'b1);
        chk("same_done_lat", longint'(done_log[$] - acc_log[$]), 3);

        // Mixed grouping
        res_log.delete();
        set_mixed();
        send_round();
        wait_done();
        chk("mixed_n", longint'(res_log.size()), 3);
        chk_res("mixed_0", 0, 3, 6, 3, 1'b0);
        chk_res("mixed_1", 1, 5, 4, 2, 1'b0);
        chk_res("mixed_2", 2, 9, 22, 11, 1'b1);

        // Backpressure with toggling out_ready
        res_log.delete();
        chk_lat = 1'b0;
        bp_mode = 1'b1;
        send_round();
        wait_done();
        bp_mode = 1'b0;
        chk("bp_n", longint'(res_log.size()), 3);
        chk_res("bp_1", 1, 5, 4, 2, 1'b0);
        chk_res("bp_2", 2, 9, 22, 11, 1'b1);
        chk_lat = 1'b1;

        // Reset in the middle of a round
        res_log.delete();
        set_mixed();
        send_round();
        begin
            int k;
            k = 0;
            while (res_log.size() < 1 && k < 50) begin @(negedge clk); #1; k++; end
        end
        chk("mid_first_result", longint'(res_log.size()), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_out_sum", longint'(out_sum), 0);
        chk("mid_rst_out_filter", longint'(out_filter), 0);
        chk("mid_rst_out_count", longint'(out_count), 0);
        chk("mid_rst_in_ready", longint'(in_ready), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        res_log.delete();
        set_distinct();
        send_round();
        wait_done();
        chk("post_rst_n", longint'(res_log.size()), 16);
        chk_res("post_rst_7", 7, 7, 8, 1, 1'b0);

        // Back-to-back rounds with in_valid held high
        res_log.delete();
        set_mixed();
        @(posedge clk); #1;
        drive_bus();
        in_valid = 1'b1;
        wait_accept();
        @(posedge clk); #1;
        set_same();
        drive_bus();
        wait_accept();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done();
        chk("b2b_n", longint'(res_log.size()), 4);
        chk_res("b2b_3", 3, 7, -1600, 16, 1'b1);
        chk("b2b_accept_in_done", longint'(acc_log[$]), longint'(done_log[done_log.size()-2]));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
